// File: rtl/ocsim_line_logger.sv
// ocsim_line_logger: assembles a valid/ready byte stream into text lines.
// Completed lines are printed and also reported on ports so benches can check them.
module ocsim_line_logger #(
   parameter int    Bytes       = 1,
   parameter int    LineBytes   = 80,
   parameter string Name        = "ocsim",
   parameter int    PrintEnable = 1
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [8*Bytes-1:0]             inData,
   input  logic [$clog2(Bytes+1)-1:0]     inBytes,
   input  logic                           inValid,
   output logic                           inReady,
   input  logic                           flush,
   output logic                           lineDone,
   output logic [$clog2(LineBytes+1)-1:0] lineLength,
   output logic                           lineWrap,
   output logic [31:0]                    lineCount,
   output logic [31:0]                    xCount,
   output logic [31:0]                    nonPrintCount
);
   localparam int CW = $clog2(Bytes+1);
   localparam int LW = $clog2(LineBytes+1);
   localparam int IW = $clog2(LineBytes);
   localparam logic [0:0] S_COLLECT = 1'b0;
   localparam logic [0:0] S_EMIT    = 1'b1;
   logic [0:0]         r_state;
   logic               r_run;
   logic               r_flush;
   logic               r_wrap;
   logic [8*Bytes-1:0] r_hold;
   logic [CW-1:0]      r_cnt;
   logic [LW-1:0]      r_len;
   logic [7:0]         r_buf [LineBytes];
   logic               w_collect;
   logic               w_consume;
   logic               w_isx;
   logic               w_lf;
   logic               w_cr;
   logic               w_store;
   logic               w_full;
   logic               w_act;
   logic               w_load;
   logic [7:0]         w_byte;
   logic [LW-1:0]      w_len_nx;
   assign w_collect  = r_state == S_COLLECT;
   assign w_consume  = w_collect && r_cnt != '0;
   assign w_byte     = r_hold[7:0];
   assign w_isx      = $isunknown(w_byte);
   assign w_lf       = !w_isx && w_byte == 8'h0a;
   assign w_cr       = !w_isx && w_byte == 8'h0d;
   assign w_store    = w_consume && !w_lf && !w_cr;
   assign w_len_nx   = r_len + LW'(1);
   assign w_full     = w_len_nx == LW'(LineBytes);
   // a pending flush only acts once the unpacker has drained
   assign w_act      = w_collect && r_cnt == '0 && r_flush;
   assign inReady    = r_run && (r_cnt == '0 || (r_cnt == CW'(1) && w_consume));
   assign w_load     = inValid && inReady && inBytes != '0;
   assign lineDone   = r_state == S_EMIT;
   assign lineLength = lineDone ? r_len : '0;
   assign lineWrap   = lineDone && r_wrap;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= S_COLLECT;
         r_run         <= 1'b0;
         r_flush       <= 1'b0;
         r_wrap        <= 1'b0;
         r_hold        <= '0;
         r_cnt         <= '0;
         r_len         <= '0;
         lineCount     <= '0;
         xCount        <= '0;
         nonPrintCount <= '0;
      end else begin
         r_run   <= 1'b1;
         r_flush <= flush || (r_flush && !w_act && !(w_consume && w_lf));
         if (w_load) begin
            r_hold <= inData;
            r_cnt  <= inBytes;
         end else if (w_consume) begin
            r_hold <= r_hold >> 8;
            r_cnt  <= r_cnt - CW'(1);
         end
         if (lineDone) begin
            r_state   <= S_COLLECT;
            r_len     <= '0;
            lineCount <= lineCount + 32'd1;
         end else if ((w_consume && w_lf) || (w_act && r_len != '0)) begin
            r_state <= S_EMIT;
            r_wrap  <= 1'b0;
         end else if (w_store) begin
            r_len   <= w_len_nx;
            r_state <= w_full ? S_EMIT : S_COLLECT;
            r_wrap  <= w_full;
         end
         if (w_store && w_isx)
            xCount <= xCount + 32'd1;
         if (w_store && !w_isx && (w_byte < 8'h20 || w_byte > 8'h7e))
            nonPrintCount <= nonPrintCount + 32'd1;
      end
   end
   always_ff @(posedge clock)
      if (w_store) r_buf[r_len[IW-1:0]] <= w_byte;
   function automatic string render(input logic [7:0] b);
      logic has_x;
      has_x = 1'b0;
      for (int k = 0; k < 8; k++) has_x = has_x | (b[k] === 1'bx);
      if (has_x) return "<XX>";
      if ($isunknown(b)) return "<ZZ>";
      if (b >= 8'h20 && b <= 8'h7e) return $sformatf("%c", b);
      return b == 8'h00 ? "<00 NULL>" : b == 8'h0d ? "<0d CR \\r>" :
             b == 8'h0a ? "<0a LF \\n>" : b == 8'h1b ? "<1b ESC>" : "<?>";
   endfunction
   function automatic string render_line();
      string s;
      s = "";
      for (int i = 0; i < LineBytes; i++)
         if (i < int'(r_len)) s = {s, render(r_buf[i])};
      return s;
   endfunction
   always_ff @(posedge clock)
      if (PrintEnable != 0 && lineDone && !reset) $display("%s: %s", Name, render_line());
endmodule

// File: tb/tb_ocsim_line_logger.sv
// tb_ocsim_line_logger: random and directed byte streams scored against a line-assembly model.
module tb_ocsim_line_logger;
   localparam int B  = 4;
   localparam int LB = 4;
   typedef struct {int len; int wrap;} line_t;
   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          inValid = 1'b0;
   logic          flush = 1'b0;
   logic [8*B-1:0] inData = '0;
   logic [2:0]    inBytes = '0;
   logic          inReady, lineDone, lineWrap;
   logic [2:0]    lineLength;
   logic [31:0]   lineCount, xCount, nonPrintCount;
   int checks = 0, failures = 0;
   int cur_len = 0, m_lines = 0, m_x = 0, m_np = 0;
   int popped = 0, ncyc = 0, last_acc = 0, last_done = 0;
   line_t exp_q[$];
   line_t e;

   ocsim_line_logger #(.Bytes(B), .LineBytes(LB), .Name("ocsim"), .PrintEnable(1)) dut (
      .clock(clock), .reset(reset), .inData(inData), .inBytes(inBytes), .inValid(inValid),
      .inReady(inReady), .flush(flush), .lineDone(lineDone), .lineLength(lineLength),
      .lineWrap(lineWrap), .lineCount(lineCount), .xCount(xCount), .nonPrintCount(nonPrintCount));

   always #5 clock = ~clock;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Line model: LF ends a line, CR vanishes, anything else is stored and may fill the line.
   task automatic model_byte(input logic [7:0] b);
      if (!$isunknown(b) && b == 8'h0a) begin
         exp_q.push_back('{cur_len, 0});
         m_lines++;
         cur_len = 0;
      end else if ($isunknown(b) || b != 8'h0d) begin
         cur_len++;
         if ($isunknown(b)) m_x++;
         else if (b < 8'h20 || b > 8'h7e) m_np++;
         if (cur_len == LB) begin
            exp_q.push_back('{LB, 1});
            m_lines++;
            cur_len = 0;
         end
      end
   endtask

   function automatic logic [8*B-1:0] pk(input logic [7:0] b0, b1, b2, b3);
      return {b3, b2, b1, b0};
   endfunction

   task automatic send_beat(input logic [8*B-1:0] d, input int n, input logic fl);
      int t;
      inData = d; inBytes = 3'(n); inValid = 1'b1; flush = fl;
      t = 0;
      @(negedge clock);
      while (!inReady && t < 50) begin
         t++;
         @(negedge clock);
      end
      if (!inReady) begin
         checks++; failures++;
         $display("FAIL accept_timeout: inReady stayed 0 for 50 cycles, expected 1");
      end else
         for (int i = 0; i < n; i++) model_byte(d[8*i +: 8]);
      @(posedge clock); #1;
      inValid = 1'b0; flush = 1'b0;
   endtask

   task automatic idle(input logic do_flush);
      repeat (12) @(posedge clock);
      #1;
      if (do_flush) begin
         flush = 1'b1;
         if (cur_len > 0) begin
            exp_q.push_back('{cur_len, 0});
            m_lines++;
            cur_len = 0;
         end
         @(posedge clock); #1;
         flush = 1'b0;
         repeat (4) @(posedge clock);
         #1;
      end
   endtask

   function automatic logic [7:0] rand_byte();
      int r;
      r = $urandom_range(0, 15);
      return r < 10 ? 8'(8'h61 + $urandom_range(0, 25)) : r < 13 ? 8'h0a :
             r == 13 ? 8'h0d : r == 14 ? 8'h1b : 8'h80;
   endfunction

   always @(negedge clock) begin
      ncyc++;
      if (reset) popped = 0;
      if (inValid && inReady) last_acc = ncyc;
      if (!reset && lineDone) begin
         last_done = ncyc;
         if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL spurious_line: got a line of length %0d, expected no line", lineLength);
         end else begin
            e = exp_q.pop_front();
            check("line_length", lineLength, e.len);
            check("line_wrap", lineWrap, e.wrap);
            check("line_count_at_done", lineCount, popped);
         end
         popped++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, expected to finish");
      $fatal(1);
   end

   initial begin
      int a, n;
      logic [7:0] xb;
      logic [8*B-1:0] d;
      repeat (2) @(negedge clock);
      check("reset_inReady", inReady, 0);
      check("reset_lineDone", lineDone, 0);
      check("reset_lineLength", lineLength, 0);
      check("reset_lineWrap", lineWrap, 0);
      check("reset_lineCount", lineCount, 0);
      check("reset_xCount", xCount, 0);
      check("reset_nonPrintCount", nonPrintCount, 0);
      @(posedge clock); #1 reset = 1'b0;
      @(negedge clock);
      check("ready_before_first_clock", inReady, 0);
      @(negedge clock);
      check("ready_after_first_clock", inReady, 1);
      @(posedge clock); #1;
      send_beat(pk("H", 0, 0, 0), 1, 0);
      send_beat(pk("i", 0, 0, 0), 1, 0);
      send_beat(pk(8'h0a, 0, 0, 0), 1, 0);
      a = last_acc;
      repeat (4) @(posedge clock);
      #1;
      check("lf_to_done_latency", last_done - a, 2);
      send_beat(pk("a", 8'h0a, "b", "c"), 4, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("ready_low_after_beat", inReady, 0);
      end
      @(posedge clock); #1;
      idle(1);
      send_beat(pk("a", "b", "c", "d"), 4, 0);
      send_beat(pk("e", "f", "g", 8'h0a), 4, 0);
      idle(0);
      xb = 8'hxx;
      send_beat(pk(xb, 8'h1b, "A", 8'h0d), 4, 0);
      send_beat(pk(8'h0a, 0, 0, 0), 1, 0);
      send_beat(pk(8'h0a, 0, 0, 0), 1, 0);
      idle(0);
      check("mid_lineCount", lineCount, m_lines);
      check("mid_xCount", xCount, m_x);
      check("mid_nonPrintCount", nonPrintCount, m_np);
      idle(1);
      send_beat(pk("z", 8'h0a, 0, 0), 2, 1);
      send_beat('0, 0, 0);
      idle(0);
      for (int k = 0; k < 150; k++) begin
         n = $urandom_range(0, B);
         d = '0;
         for (int i = 0; i < B; i++) d[8*i +: 8] = rand_byte();
         send_beat(d, n, 0);
         repeat ($urandom_range(0, 2)) @(posedge clock);
         #1;
         if ($urandom_range(0, 9) == 0) idle(1);
      end
      idle(0);
      check("rand_lineCount", lineCount, m_lines);
      check("rand_xCount", xCount, m_x);
      check("rand_nonPrintCount", nonPrintCount, m_np);
      check("rand_lines_outstanding", exp_q.size(), 0);
      send_beat(pk("a", "b", "c", 0), 3, 0);
      @(posedge clock); #1 reset = 1'b1;
      cur_len = 0; m_lines = 0; m_x = 0; m_np = 0;
      exp_q.delete();
      @(negedge clock);
      check("midline_reset_inReady", inReady, 0);
      check("midline_reset_lineCount", lineCount, 0);
      @(posedge clock); #1 reset = 1'b0;
      @(posedge clock); #1;
      send_beat(pk("d", 8'h0a, 0, 0), 2, 0);
      idle(0);
      check("after_reset_lineCount", lineCount, m_lines);
      check("after_reset_lines_outstanding", exp_q.size(), 0);
      check("after_reset_nonPrintCount", nonPrintCount, m_np);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
